// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
//   Shared constants and types for the SPI target endpoint.
//   SPI_WIDTH        default bits per SPI word
//   SPI_SYNC_STAGES  default synchronizer depth on each pin input
//   SPI_CPOL         idle level of sck (mode 0: low, data MSB first)
//   link_state_e     select state of the endpoint
package spi_slave_pkg;

  localparam int   SPI_WIDTH       = 8;
  localparam int   SPI_SYNC_STAGES = 2;
  localparam logic SPI_CPOL        = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } link_state_e;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// spi_slave_sync_edge
//   Pin synchronizer with registered rise/fall pulses.
//   clk   in   system clock
//   rst   in   synchronous active-low reset
//   din   in   asynchronous pin
//   rise  out  1-cycle pulse on a synchronized 0->1 transition
//   fall  out  1-cycle pulse on a synchronized 1->0 transition
// The pulses leave this block STAGES+1 clk after the pin changes, which is
// where the endpoint's new_data latency of SYNC_STAGES+2 comes from.
module spi_slave_sync_edge
  import spi_slave_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // reset to the pin's idle level so leaving reset creates no edge
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// spi_slave
//   SPI target endpoint, mode 0, MSB first, oversampled in the clk domain
//   (f_clk >= 4 * f_sck).
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   ss_n         in   slave select, active low, async
//   sck          in   SPI clock, async, idle low
//   mosi         in   serial data from master
//   miso         out  serial data to master (0 while deselected)
//   miso_oe      out  miso pad enable, high while selected
//   data_in      in   next reply word
//   load         in   strobe: data_in -> tx buffer
//   tx_full      out  tx buffer holds an unconsumed word
//   data_out     out  last complete received word
//   new_data     out  1-cycle pulse, data_out updated
//   tx_underrun  out  1-cycle pulse, word started with empty tx buffer
//   busy         out  synchronized select active
//
//   state     | meaning
//   ST_IDLE   | deselected: sck ignored, miso/miso_oe held low
//   ST_ACTIVE | selected: shifting words, miso driven from tx_shift
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss_n,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             tx_full,
  output logic [WIDTH-1:0] data_out,
  output logic             new_data,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_sync;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;
  link_state_e            state;
  logic                   selected;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WIDTH-1:0]       rx_shift, rx_next, tx_shift, tx_buf, tx_reload;
  logic                   take;

  spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ss_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  assign mosi_sync = mosi_q[SYNC_STAGES-1];
  assign selected  = (state == ST_ACTIVE);
  assign busy      = selected;
  assign miso_oe   = selected;
  assign miso      = selected & tx_shift[WIDTH-1];

  // take: the shifter fetches a new reply word, either at select or on the
  // sck fall right after a word completed (bit_cnt wrapped to 0).
  always_comb begin
    rx_next   = {rx_shift[WIDTH-2:0], mosi_sync};
    tx_reload = tx_full ? tx_buf : '0;
    take      = ss_fall | (selected & ~ss_rise & sck_fall & (bit_cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mosi_q      <= '0;
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      data_out    <= '0;
      new_data    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
      new_data    <= 1'b0;
      tx_underrun <= take & ~tx_full;

      if (take) tx_shift <= tx_reload;

      // select edges take priority over any sck edge in the same cycle
      if (ss_fall) begin
        state    <= ST_ACTIVE;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (ss_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else if (selected) begin
        if (sck_rise) begin
          rx_shift <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            data_out <= rx_next;
            new_data <= 1'b1;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else if (sck_fall && bit_cnt != '0) begin
          tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        end
      end

      // a load coinciding with a fetch: old word went to the shifter above,
      // new word is kept and the buffer stays full
      if (load) begin
        tx_buf  <= data_in;
        tx_full <= 1'b1;
      end else if (take) begin
        tx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int  CLK_HALF = 10;
  localparam time LAT      = 4 * 20;   // SYNC_STAGES+2 clk of 20 ns

  logic       clk, rst, ss_n, sck, mosi, miso, miso_oe, load, tx_full;
  logic       new_data, tx_underrun, busy;
  logic [7:0] data_in, data_out;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ss_n        (ss_n),
    .sck         (sck),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .data_in     (data_in),
    .load        (load),
    .tx_full     (tx_full),
    .data_out    (data_out),
    .new_data    (new_data),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int nd_seen  = 0;
  int ur_seen  = 0;
  bit chk_en   = 1'b0;

  // transaction-level model: one-entry reply buffer, last received word,
  // and the absolute times at which pulses must be visible
  logic [7:0] m_buf;
  bit         m_full;
  logic [7:0] m_dout;
  time        nd_due[$];
  logic [7:0] nd_word[$];
  time        ur_due[$];

  logic [7:0] f_mosi[4];
  bit         f_ld[4];
  logic [7:0] f_ldv[4];
  logic [7:0] cap[4];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every fetch of a reply word; an empty buffer yields 0 and an underrun pulse
  task automatic consume(output logic [7:0] w);
    if (m_full) begin
      w      = m_buf;
      m_full = 1'b0;
    end else begin
      w = 8'h00;
      ur_due.push_back($time + LAT);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load    = 1'b1;
    data_in = v;
    @(negedge clk);
    load   = 1'b0;
    m_buf  = v;
    m_full = 1'b1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 4; i++) begin
      f_ld[i]   = 1'b0;
      f_ldv[i]  = 8'h00;
      f_mosi[i] = 8'h00;
    end
  endtask

  task automatic check_idle_pins();
    chk1("busy_idle", busy, 1'b0);
    chk1("miso_oe_idle", miso_oe, 1'b0);
    chk1("miso_idle", miso, 1'b0);
  endtask

  task automatic abort_frame(input bit with_rst);
    if (with_rst) begin
      chk_en = 1'b0;
      rst    = 1'b0;
      ss_n   = 1'b1;
      sck    = 1'b0;
      repeat (3) @(negedge clk);
      chk8("rst_data_out", data_out, 8'h00);
      chk1("rst_tx_full", tx_full, 1'b0);
      chk1("rst_new_data", new_data, 1'b0);
      chk1("rst_tx_underrun", tx_underrun, 1'b0);
      check_idle_pins();
      rst    = 1'b1;
      m_full = 1'b0;
      m_dout = 8'h00;
      nd_due.delete();
      nd_word.delete();
      ur_due.delete();
      repeat (4) @(negedge clk);
      chk_en = 1'b1;
    end else begin
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
      check_idle_pins();
    end
  endtask

  // cut >= 0: stop after that many completed bits (ss_n rise or reset)
  task automatic run_frame(input int nw, input int cut, input bit cut_rst);
    logic [7:0] exp_w, got;
    int done;
    done = 0;
    ss_n = 1'b0;
    consume(exp_w);
    repeat (8) @(negedge clk);
    for (int w = 0; w < nw; w++) begin
      got = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        if (done == cut) begin
          abort_frame(cut_rst);
          return;
        end
        if (b == 3 && f_ld[w]) do_load(f_ldv[w]);
        mosi = f_mosi[w][b];
        repeat (4) @(negedge clk);
        got = {got[6:0], miso};
        chk1("busy_sel", busy, 1'b1);
        chk1("miso_oe_sel", miso_oe, 1'b1);
        chk1("tx_full", tx_full, m_full);
        sck = 1'b1;
        if (b == 0) begin
          nd_due.push_back($time + LAT);
          nd_word.push_back(f_mosi[w]);
        end
        repeat (4) @(negedge clk);
        sck = 1'b0;
        done++;
      end
      cap[w] = got;
      chk8("miso_word", got, exp_w);
      consume(exp_w);
    end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check_idle_pins();
  endtask

  // per-cycle compare of the pulse outputs and data_out against the model
  always @(negedge clk) begin : compare
    bit exp_nd, exp_ur;
    if (chk_en) begin
      exp_nd = (nd_due.size() > 0) && (nd_due[0] == $time);
      if (exp_nd) begin
        m_dout = nd_word[0];
        void'(nd_due.pop_front());
        void'(nd_word.pop_front());
      end
      exp_ur = (ur_due.size() > 0) && (ur_due[0] == $time);
      if (exp_ur) void'(ur_due.pop_front());
      chk1("new_data", new_data, exp_nd);
      chk8("data_out", data_out, m_dout);
      chk1("tx_underrun", tx_underrun, exp_ur);
      if (new_data) nd_seen++;
      if (tx_underrun) ur_seen++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nd0, ur0, nw, cut;
    rst     = 1'b0;
    ss_n    = 1'($urandom);
    sck     = 1'($urandom);
    mosi    = 1'($urandom);
    load    = 1'b0;
    data_in = 8'h00;
    m_buf   = 8'h00;
    m_full  = 1'b0;
    m_dout  = 8'h00;
    clear_frame();

    // 1: reset with wiggling pins
    repeat (3) begin
      @(negedge clk);
      chk8("rst_data_out", data_out, 8'h00);
      chk1("rst_tx_full", tx_full, 1'b0);
      chk1("rst_new_data", new_data, 1'b0);
      chk1("rst_tx_underrun", tx_underrun, 1'b0);
      check_idle_pins();
      ss_n = 1'($urandom);
      sck  = 1'($urandom);
      mosi = 1'($urandom);
    end
    ss_n = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 1'b1;

    // 2: single word, load overwritten before the transfer
    do_load(8'h77);
    do_load(8'hA5);
    chk1("tx_full_loaded", tx_full, 1'b1);
    clear_frame();
    f_mosi[0] = 8'hCA;
    nd0 = nd_seen;
    run_frame(1, -1, 1'b0);
    chk8("t2_data_out", data_out, 8'hCA);
    chk8("t2_miso", cap[0], 8'hA5);
    chk_int("t2_pulses", nd_seen - nd0, 1);
    chk1("t2_tx_full", tx_full, 1'b0);

    // 3: back-to-back words, reply loaded mid first word
    clear_frame();
    f_mosi[0] = 8'h11;
    f_mosi[1] = 8'h22;
    f_ld[0]   = 1'b1;
    f_ldv[0]  = 8'h3C;
    nd0 = nd_seen;
    run_frame(2, -1, 1'b0);
    chk8("t3_data_out", data_out, 8'h22);
    chk8("t3_miso0", cap[0], 8'h00);
    chk8("t3_miso1", cap[1], 8'h3C);
    chk_int("t3_pulses", nd_seen - nd0, 2);

    // 4: nothing loaded; select and the end-of-word refetch both find it empty
    clear_frame();
    f_mosi[0] = 8'h96;
    ur0 = ur_seen;
    run_frame(1, -1, 1'b0);
    chk8("t4_miso", cap[0], 8'h00);
    chk_int("t4_underruns", ur_seen - ur0, 2);

    // 5: deselect after 5 bits, then a full word
    clear_frame();
    f_mosi[0] = 8'hFF;
    nd0 = nd_seen;
    run_frame(1, 5, 1'b0);
    chk_int("t5_no_pulse", nd_seen - nd0, 0);
    chk8("t5_held", data_out, 8'h96);
    f_mosi[0] = 8'h81;
    run_frame(1, -1, 1'b0);
    chk8("t5_data_out", data_out, 8'h81);

    // 6: reset during bit 4, then a clean word
    do_load(8'hE7);
    clear_frame();
    f_mosi[0] = 8'h3C;
    run_frame(1, 4, 1'b1);
    f_mosi[0] = 8'h5A;
    run_frame(1, -1, 1'b0);
    chk8("t6_data_out", data_out, 8'h5A);
    chk8("t6_miso", cap[0], 8'h00);

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      clear_frame();
      nw = int'($urandom_range(1, 3));
      for (int i = 0; i < nw; i++) begin
        f_mosi[i] = 8'($urandom);
        f_ld[i]   = 1'($urandom);
        f_ldv[i]  = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) do_load(8'($urandom));
      cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nw * 8 - 1)) : -1;
      run_frame(nw, cut, 1'b0);
    end

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
